mux_scan_ctrl: RTL

Upstream select sequencer for the 4:1 select mux `muxB_4_1`. It drives `sel1`/`sel0` to step through the enabled mux inputs in order, holds each select for a programmable settle time, and samples the mux output. It assembles one bit per channel into a 4-bit frame and publishes completed frames downstream. Channel index is `{sel1, sel0}`: A=0, B=1, C=2, D=3.

---
 rtl/mux_pkg.sv | 15 +
 rtl/next_chan_4.sv | 29 ++
 rtl/mux_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 mux select sequencer: channel count,
// channel-index type and the scan state encoding.
package mux_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef logic [CH_W-1:0] chan_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SETTLE = 1'b1
   } state_t;

endpackage

// File: rtl/next_chan_4.sv
// Channel walker: given a channel index and an enable mask, reports the
// lowest enabled channel, the next higher enabled channel and whether none is left.
module next_chan_4
   import mux_pkg::*;
(
   input  logic [CH_W-1:0]   cur,
   input  logic [NUM_CH-1:0] mask,
   output logic [CH_W-1:0]   first,
   output logic [CH_W-1:0]   next,
   output logic              last
);

   // Scanning from the top down lets the lowest qualifying index win.
   always_comb begin
      first = '0;
      next  = '0;
      last  = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first = chan_t'(i);
         end
         if (mask[i] && (i > int'(cur))) begin
            next = chan_t'(i);
            last = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for muxB_4_1: steps the select through enabled channels,
// waits dwell+1 cycles on each, samples the mux output and publishes 4-bit frames.
module mux_scan_ctrl
   import mux_pkg::*;
#(
   parameter int DWELL_W = 4
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NUM_CH-1:0]  chan_mask,
   input  logic               mux_out,
   output logic               sel0,
   output logic               sel1,
   output logic               sample_valid,
   output logic               sample_bit,
   output logic [CH_W-1:0]    sample_chan,
   output logic [NUM_CH-1:0]  frame,
   output logic               frame_done,
   output logic               busy
);

   state_t               state_q, state_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [NUM_CH-1:0]    mask_q, mask_d;
   logic                 cont_q, cont_d;
   logic [CH_W-1:0]      sel_q, sel_d;
   logic [NUM_CH-1:0]    work_q, work_d;
   logic [NUM_CH-1:0]    frame_q, frame_d;
   logic                 frame_done_q, frame_done_d;
   logic                 sample_valid_q, sample_valid_d;
   logic                 sample_bit_q, sample_bit_d;
   logic [CH_W-1:0]      sample_chan_q, sample_chan_d;

   logic [NUM_CH-1:0]    scan_mask;
   logic [NUM_CH-1:0]    captured;
   logic [CH_W-1:0]      ch_first;
   logic [CH_W-1:0]      ch_next;
   logic                 ch_last;

   // In IDLE the walker looks at the live mask to find the starting channel;
   // once scanning it only ever sees the mask latched at start.
   assign scan_mask = (state_q == ST_IDLE) ? chan_mask : mask_q;

   next_chan_4 u_next_chan (
      .cur   (sel_q),
      .mask  (scan_mask),
      .first (ch_first),
      .next  (ch_next),
      .last  (ch_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         dwell_q        <= '0;
         mask_q         <= '0;
         cont_q         <= 1'b0;
         sel_q          <= '0;
         work_q         <= '0;
         frame_q        <= '0;
         frame_done_q   <= 1'b0;
         sample_valid_q <= 1'b0;
         sample_bit_q   <= 1'b0;
         sample_chan_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         dwell_q        <= dwell_d;
         mask_q         <= mask_d;
         cont_q         <= cont_d;
         sel_q          <= sel_d;
         work_q         <= work_d;
         frame_q        <= frame_d;
         frame_done_q   <= frame_done_d;
         sample_valid_q <= sample_valid_d;
         sample_bit_q   <= sample_bit_d;
         sample_chan_q  <= sample_chan_d;
      end
   end

   // Stop outranks a capture that falls due in the same cycle, so an aborted
   // scan never emits a partial sample or frame.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      dwell_d        = dwell_q;
      mask_d         = mask_q;
      cont_d         = cont_q;
      sel_d          = sel_q;
      work_d         = work_q;
      frame_d        = frame_q;
      frame_done_d   = 1'b0;
      sample_valid_d = 1'b0;
      sample_bit_d   = sample_bit_q;
      sample_chan_d  = sample_chan_q;

      captured        = work_q;
      captured[sel_q] = mux_out;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop && (chan_mask != '0)) begin
               state_d = ST_SETTLE;
               mask_d  = chan_mask;
               dwell_d = dwell;
               cont_d  = cont;
               cnt_d   = dwell;
               sel_d   = ch_first;
               work_d  = '0;
            end
         end

         ST_SETTLE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               sample_valid_d = 1'b1;
               sample_bit_d   = mux_out;
               sample_chan_d  = sel_q;
               work_d         = captured;
               if (!ch_last) begin
                  sel_d = ch_next;
                  cnt_d = dwell_q;
               end else begin
                  frame_d      = captured;
                  frame_done_d = 1'b1;
                  if (cont_q) begin
                     work_d = '0;
                     cnt_d  = dwell_q;
                     sel_d  = ch_first;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign sel0         = sel_q[0];
   assign sel1         = sel_q[1];
   assign sample_valid = sample_valid_q;
   assign sample_bit   = sample_bit_q;
   assign sample_chan  = sample_chan_q;
   assign frame        = frame_q;
   assign frame_done   = frame_done_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
